// File: rtl/udp_perf_pkg.sv
// Shared widths, FSM state encoding and beat-geometry helpers for the
// UDP performance transmit generator.
package udp_perf_pkg;

  localparam int AXIS_DATA_W    = 512;
  localparam int AXIS_KEEP_W    = 64;
  localparam int AXIS_USER_W    = 1;
  localparam int BYTES_PER_BEAT = 64;
  localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int BEAT_CNT_W     = 32 - BEAT_SHIFT + 1;
  localparam int IDX_REPL       = AXIS_DATA_W / 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // ceil(size / 64); one extra bit so a 0xFFFFFFFF-byte packet still fits
  function automatic logic [BEAT_CNT_W-1:0] beats_for_size(input logic [31:0] size);
    return {1'b0, size[31:BEAT_SHIFT]} +
           {{(BEAT_CNT_W-1){1'b0}}, (size[BEAT_SHIFT-1:0] != {BEAT_SHIFT{1'b0}})};
  endfunction

  function automatic logic [AXIS_KEEP_W-1:0] last_keep(input logic [BEAT_SHIFT-1:0] rem);
    return (rem == {BEAT_SHIFT{1'b0}}) ? {AXIS_KEEP_W{1'b1}}
                                       : ((64'd1 << rem) - 64'd1);
  endfunction

endpackage

// File: rtl/udp_perf_sat_counter.sv
// 32-bit event counter with synchronous clear that sticks at all ones
// instead of wrapping.
module udp_perf_sat_counter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // Count register: clear has priority, increment stops at saturation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 32'd0;
    end else if (i_clr) begin
      r_count <= 32'd0;
    end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/udp_perf_tx_gen.sv
// AXI-Stream packet generator for throughput measurement: emits cfg_pkt_num
// packets of cfg_pkt_size bytes, tdata carrying the run-global beat index.
module udp_perf_tx_gen
  import udp_perf_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [31:0]            cfg_pkt_size,
  input  logic [31:0]            cfg_pkt_num,
  input  logic                   cfg_start,
  output logic                   tx_axis_tvalid,
  output logic [AXIS_DATA_W-1:0] tx_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] tx_axis_tkeep,
  output logic                   tx_axis_tlast,
  output logic [AXIS_USER_W-1:0] tx_axis_tuser,
  input  logic                   tx_axis_tready,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            perf_cycle_counter,
  output logic [31:0]            total_beat_counter,
  output logic [31:0]            total_pkt_counter
);

  localparam logic              LP_NO_GAP   = (GAP_CYCLES == 0);
  localparam logic [31:0]       LP_GAP_LOAD = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [AXIS_KEEP_W-1:0] KEEP_ALL = {AXIS_KEEP_W{1'b1}};

  state_e                  r_state,         w_state_nxt;
  logic [BEAT_SHIFT-1:0]   r_size_rem,      w_size_rem_nxt;
  logic [31:0]             r_num,           w_num_nxt;
  logic [BEAT_CNT_W-1:0]   r_beats,         w_beats_nxt;
  logic [BEAT_CNT_W-1:0]   r_beat_in_pkt,   w_beat_in_pkt_nxt;
  logic [31:0]             r_pkt_in_run,    w_pkt_in_run_nxt;
  logic [31:0]             r_beat_idx,      w_beat_idx_nxt;
  logic [31:0]             r_gap_cnt,       w_gap_cnt_nxt;
  logic                    r_tvalid,        w_tvalid_nxt;
  logic                    r_tlast,         w_tlast_nxt;
  logic [AXIS_KEEP_W-1:0]  r_tkeep,         w_tkeep_nxt;
  logic                    r_done,          w_done_nxt;
  logic                    r_busy,          w_busy_nxt;

  logic                    w_clr;
  logic                    w_hs;
  logic [BEAT_CNT_W-1:0]   w_cfg_beats;
  logic                    w_cfg_single;
  logic [BEAT_CNT_W-1:0]   w_beat_in_pkt_inc;
  logic                    w_next_is_last;
  logic                    w_single_beat;
  logic                    w_last_pkt;
  logic [AXIS_KEEP_W-1:0]  w_last_keep;

  assign w_hs              = r_tvalid && tx_axis_tready;
  assign w_cfg_beats       = beats_for_size(cfg_pkt_size);
  assign w_cfg_single      = (w_cfg_beats == {{(BEAT_CNT_W-1){1'b0}}, 1'b1});
  assign w_beat_in_pkt_inc = r_beat_in_pkt + {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
  assign w_next_is_last    = (w_beat_in_pkt_inc == (r_beats - {{(BEAT_CNT_W-1){1'b0}}, 1'b1}));
  assign w_single_beat     = (r_beats == {{(BEAT_CNT_W-1){1'b0}}, 1'b1});
  assign w_last_pkt        = (r_pkt_in_run == (r_num - 32'd1));
  assign w_last_keep       = last_keep(r_size_rem);

  // Next-state and next-beat decode; each presented beat is fully prepared one cycle ahead.
  always_comb begin
    w_state_nxt       = r_state;
    w_size_rem_nxt    = r_size_rem;
    w_num_nxt         = r_num;
    w_beats_nxt       = r_beats;
    w_beat_in_pkt_nxt = r_beat_in_pkt;
    w_pkt_in_run_nxt  = r_pkt_in_run;
    w_beat_idx_nxt    = r_beat_idx;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_tvalid_nxt      = r_tvalid;
    w_tlast_nxt       = r_tlast;
    w_tkeep_nxt       = r_tkeep;
    w_done_nxt        = r_done;
    w_clr             = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (cfg_start) begin
          w_clr             = 1'b1;
          w_done_nxt        = 1'b0;
          w_size_rem_nxt    = cfg_pkt_size[BEAT_SHIFT-1:0];
          w_num_nxt         = cfg_pkt_num;
          w_beats_nxt       = w_cfg_beats;
          w_beat_in_pkt_nxt = {BEAT_CNT_W{1'b0}};
          w_pkt_in_run_nxt  = 32'd0;
          w_beat_idx_nxt    = 32'd0;
          if ((cfg_pkt_size == 32'd0) || (cfg_pkt_num == 32'd0)) begin
            w_state_nxt  = ST_DONE;
            w_done_nxt   = 1'b1;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
          end else begin
            w_state_nxt  = ST_SEND;
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = w_cfg_single;
            w_tkeep_nxt  = w_cfg_single ? last_keep(cfg_pkt_size[BEAT_SHIFT-1:0]) : KEEP_ALL;
          end
        end else begin
          w_tvalid_nxt = 1'b0;
          w_tlast_nxt  = 1'b0;
        end
      end
      ST_SEND: begin
        if (w_hs) begin
          w_beat_idx_nxt = r_beat_idx + 32'd1;
          if (r_tlast) begin
            w_beat_in_pkt_nxt = {BEAT_CNT_W{1'b0}};
            if (w_last_pkt) begin
              w_state_nxt  = ST_DONE;
              w_done_nxt   = 1'b1;
              w_tvalid_nxt = 1'b0;
              w_tlast_nxt  = 1'b0;
            end else begin
              w_pkt_in_run_nxt = r_pkt_in_run + 32'd1;
              if (LP_NO_GAP) begin
                w_tvalid_nxt = 1'b1;
                w_tlast_nxt  = w_single_beat;
                w_tkeep_nxt  = w_single_beat ? w_last_keep : KEEP_ALL;
              end else begin
                w_state_nxt   = ST_GAP;
                w_tvalid_nxt  = 1'b0;
                w_tlast_nxt   = 1'b0;
                w_gap_cnt_nxt = LP_GAP_LOAD;
              end
            end
          end else begin
            w_beat_in_pkt_nxt = w_beat_in_pkt_inc;
            w_tlast_nxt       = w_next_is_last;
            w_tkeep_nxt       = w_next_is_last ? w_last_keep : KEEP_ALL;
          end
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 32'd0) begin
          w_state_nxt  = ST_SEND;
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = w_single_beat;
          w_tkeep_nxt  = w_single_beat ? w_last_keep : KEEP_ALL;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 32'd1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_SEND) || (w_state_nxt == ST_GAP);
  end

  // State and registered AXIS outputs; reset abandons any partial packet.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_size_rem    <= {BEAT_SHIFT{1'b0}};
      r_num         <= 32'd0;
      r_beats       <= {BEAT_CNT_W{1'b0}};
      r_beat_in_pkt <= {BEAT_CNT_W{1'b0}};
      r_pkt_in_run  <= 32'd0;
      r_beat_idx    <= 32'd0;
      r_gap_cnt     <= 32'd0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tkeep       <= {AXIS_KEEP_W{1'b0}};
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_size_rem    <= w_size_rem_nxt;
      r_num         <= w_num_nxt;
      r_beats       <= w_beats_nxt;
      r_beat_in_pkt <= w_beat_in_pkt_nxt;
      r_pkt_in_run  <= w_pkt_in_run_nxt;
      r_beat_idx    <= w_beat_idx_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_tvalid      <= w_tvalid_nxt;
      r_tlast       <= w_tlast_nxt;
      r_tkeep       <= w_tkeep_nxt;
      r_done        <= w_done_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  udp_perf_sat_counter u_cycle_cnt (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clr   (w_clr),
    .i_inc   (r_busy),
    .o_count (perf_cycle_counter)
  );

  udp_perf_sat_counter u_beat_cnt (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clr   (w_clr),
    .i_inc   (w_hs),
    .o_count (total_beat_counter)
  );

  udp_perf_sat_counter u_pkt_cnt (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clr   (w_clr),
    .i_inc   (w_hs && r_tlast),
    .o_count (total_pkt_counter)
  );

  assign tx_axis_tvalid = r_tvalid;
  assign tx_axis_tdata  = {IDX_REPL{r_beat_idx}};
  assign tx_axis_tkeep  = r_tkeep;
  assign tx_axis_tlast  = r_tlast;
  assign tx_axis_tuser  = {AXIS_USER_W{1'b0}};
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: doc/udp_perf_tx_gen.md
UDP_PERF_TX_GEN -- requirements
Module: udp_perf_tx_gen

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0: number of idle cycles inserted after each packet's last accepted beat.
REQ-002 SHALL have port CLK, input, 1: the single clock for all logic.
REQ-003 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cfg_pkt_size, input, 32: packet length in bytes.
REQ-005 SHALL have port cfg_pkt_num, input, 32: number of packets per run.
REQ-006 SHALL have port cfg_start, input, 1: single-cycle run request.
REQ-007 SHALL have port tx_axis_tvalid, output, 1: AXI-Stream valid.
REQ-008 SHALL have port tx_axis_tdata, output, 512: AXI-Stream data.
REQ-009 SHALL have port tx_axis_tkeep, output, 64: AXI-Stream byte enables.
REQ-010 SHALL have port tx_axis_tlast, output, 1: last beat of a packet.
REQ-011 SHALL have port tx_axis_tuser, output, 1: constant 0.
REQ-012 SHALL have port tx_axis_tready, input, 1: AXI-Stream ready.
REQ-013 SHALL have port busy, output, 1: high while a run is in progress.
REQ-014 SHALL have port done, output, 1: high from run completion until the next accepted start.
REQ-015 SHALL have port perf_cycle_counter, output, 32: cycles spent in the current or last run.
REQ-016 SHALL have port total_beat_counter, output, 32: beats accepted in the current or last run.
REQ-017 SHALL have port total_pkt_counter, output, 32: packets accepted in the current or last run.

Function
REQ-018 SHALL implement FSM IDLE, SEND, GAP, DONE.
REQ-019 SHALL accept cfg_start only in IDLE or DONE; cfg_start in SEND or GAP SHALL be ignored.
REQ-020 On an accepted start, SHALL latch cfg_pkt_size and cfg_pkt_num, clear all three counters, clear done, and enter SEND.
REQ-021 When an accepted start has cfg_pkt_size==0 or cfg_pkt_num==0, SHALL enter DONE the next cycle with all counters 0 and no beats emitted.
REQ-022 SHALL drive tvalid in the cycle after an accepted start (1-cycle latency), with all AXIS outputs registered.
REQ-023 A handshake occurs when tvalid && tready; once tvalid is asserted, tvalid, tdata, tkeep and tlast SHALL stay stable until the handshake.
REQ-024 Beats per packet SHALL be ceil(size/64).
REQ-025 Every non-last beat SHALL carry tkeep of all ones.
REQ-026 The last beat SHALL carry tkeep with the low (size mod 64) bits set, or all ones when size mod 64 == 0.
REQ-027 tlast SHALL be asserted only on the last beat of each packet.
REQ-028 tdata SHALL be 16 replicated copies of the 32-bit run-global beat index, starting at 0 and wrapping modulo 2^32.
REQ-029 After the tlast handshake, SHALL go to GAP for GAP_CYCLES cycles, or straight back to SEND when GAP_CYCLES==0, with no idle bubble.
REQ-030 After the final packet's tlast handshake, SHALL enter DONE; done SHALL rise in the following cycle, with tvalid low.
REQ-031 perf_cycle_counter SHALL increment in every cycle spent in SEND or GAP.
REQ-032 total_beat_counter SHALL increment on every handshake.
REQ-033 total_pkt_counter SHALL increment on every handshake with tlast high.
REQ-034 All three counters SHALL saturate at 0xFFFFFFFF and SHALL NOT wrap.
REQ-035 Backpressure (tready low) SHALL stall only the beat; the cycle counter keeps running.
REQ-036 busy SHALL equal (state==SEND || state==GAP).

Reset
REQ-037 While RST_N is low, SHALL immediately force state=IDLE and tvalid, tlast, busy and done to 0, independent of CLK.
REQ-038 Reset SHALL clear tdata, tkeep and all counters to 0, including when asserted mid-packet; no partial packet resumes after reset.

Structure
REQ-039 Package udp_perf_pkg SHALL hold the AXIS widths (512/64/1), the bytes-per-beat constant 64, and the FSM state enum.
REQ-040 Counter saturation SHALL live in one sub-module, udp_perf_sat_counter (32-bit, clear/inc/saturate), instantiated three times.

Verification
REQ-041 Bench SHALL cover: size=64, num=3, tready=1 -> 3 beats, each tlast=1 and tkeep=all ones; beat=3, pkt=3; done rises 1 cycle after the 3rd handshake.
REQ-042 Bench SHALL cover: size=130, num=2 -> 3 beats per packet; last tkeep=0x3; tdata indices 0..5; pkt=2, beat=6.
REQ-043 Bench SHALL cover: size=200, num=4 with random tready -> tdata, tkeep and tlast are stable while stalled; beat=16; cycle counter >= 16.
REQ-044 Bench SHALL cover: GAP_CYCLES=2, size=64, num=2 -> exactly 2 idle cycles between the two handshakes.
REQ-045 Bench SHALL cover: size=0, and separately num=0 -> done 1 cycle after start, no tvalid, all counters 0.
REQ-046 Bench SHALL cover: RST_N low mid-packet, then a new start -> tvalid drops asynchronously; the new run begins at beat index 0 with cleared counters.
